// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial link transmitter and receiver.
//   - FSM state encodings (3-bit)
//   - line levels for start, stop and idle
//   - cnt_width(): counter width helper (clog2 with a floor of 1 bit)
package serial_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  // Width of a counter that must hold 0..n-1. Never returns 0.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// bit_timer: baud counter for the serial link.
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset
//   run      : count while high; counter is held at 0 while low
//   tick     : high on the last cycle of each CLKS_PER_BIT bit period
//   pre_tick : high on the second-to-last cycle of a bit period
//              (never high when CLKS_PER_BIT == 1)
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || !run) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  assign tick     = run && (cnt == LAST);
  assign pre_tick = (CLKS_PER_BIT > 1) && run && (cnt == PRE);

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter.
//   Frame on tx: start(0), DATA_WIDTH data bits LSB first, optional even
//   parity, stop(1). Each bit lasts CLKS_PER_BIT clocks.
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset
//   data_in : word to send, sampled on load && ready
//   load    : send request
//   ready   : idle, a load is accepted this cycle
//   tx      : registered serial line, idles at 1
//   busy    : frame in progress (!ready)
//   done    : one-cycle pulse, coincides with ready rising
//
// The final cycle of the stop bit is spent in IDLE with done high, so a
// load presented alongside done starts the next frame with no gap. The
// STOP state therefore covers only CLKS_PER_BIT-1 cycles (left on
// pre_tick), and is skipped outright when CLKS_PER_BIT == 1.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = cnt_width(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);
  // Where the last payload bit hands over to the stop bit.
  localparam logic       STOP_IN_IDLE = (CLKS_PER_BIT == 1);
  localparam logic [2:0] STOP_NEXT    = STOP_IN_IDLE ? S_IDLE : S_STOP;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par;
  logic [IW-1:0]         bidx;
  logic                  tick, pre_tick;

  assign ready = (state == S_IDLE);
  assign busy  = !ready;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .run      (busy),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      tx    <= IDLE_LEVEL;
      shreg <= '0;
      par   <= 1'b0;
      bidx  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (load) begin
          state <= S_START;
          tx    <= START_LEVEL;
          shreg <= data_in;
          par   <= ^data_in;
          bidx  <= '0;
        end
        S_START: if (tick) begin
          state <= S_DATA;
          tx    <= shreg[0];
          shreg <= shreg >> 1;
        end
        S_DATA: if (tick) begin
          if (bidx == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state <= S_PARITY;
              tx    <= par;
            end else begin
              state <= STOP_NEXT;
              tx    <= STOP_LEVEL;
              done  <= STOP_IN_IDLE;
            end
          end else begin
            bidx  <= bidx + IW'(1);
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        S_PARITY: if (tick) begin
          state <= STOP_NEXT;
          tx    <= STOP_LEVEL;
          done  <= STOP_IN_IDLE;
        end
        S_STOP: if (pre_tick) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic       l0 = 1'b0, l1 = 1'b0, l2 = 1'b0;
  wire  [2:0] tx_v, done_v, ready_v, busy_v;

  int checks = 0;
  int errors = 0;

  // expected frames: {hand-computed parity, data}
  logic [8:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  // dut0: defaults, dut1: no parity, dut2: one clock per bit
  serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
    .clock(clk), .reset(rst), .data_in(d0), .load(l0),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut1 (
    .clock(clk), .reset(rst), .data_in(d1), .load(l1),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut2 (
    .clock(clk), .reset(rst), .data_in(d2), .load(l2),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [8:0] e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [8:0] qpop(input int id);
    case (id)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // per-cycle tx pattern of a frame, bit 0 = first cycle
  function automatic logic [63:0] exp_frame(input logic [8:0] e, input int cpb, input int pe);
    logic [11:0] b;
    logic [63:0] r;
    int nb;
    nb = 10 + pe;
    b = '0;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = e[i];
    if (pe != 0) b[9] = e[8];
    b[nb-1] = 1'b1;
    r = '0;
    for (int j = 0; j < nb; j++)
      for (int c = 0; c < cpb; c++) r[j*cpb+c] = b[j];
    return r;
  endfunction

  task automatic monitor(input int id, input int cpb, input int pe);
    logic [63:0] seen, dseen, rseen, one;
    logic [8:0] e;
    int total;
    bit abort;
    total = (10 + pe) * cpb;
    one = 64'd1 << (total - 1);
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx_v[id] !== 1'b0) continue;
      seen = '0; dseen = '0; rseen = '0; abort = 0;
      for (int k = 0; k < total; k++) begin
        if (k > 0) @(negedge clk);
        if (rst) begin abort = 1; break; end
        seen[k] = tx_v[id]; dseen[k] = done_v[id]; rseen[k] = ready_v[id];
      end
      if (abort) continue;
      if (qsize(id) == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame dut%0d: got frame %0h, required none", id, seen);
        continue;
      end
      e = qpop(id);
      check($sformatf("frame_tx dut%0d data %0h", id, e[7:0]), seen, exp_frame(e, cpb, pe));
      check($sformatf("frame_done dut%0d data %0h", id, e[7:0]), dseen, one);
      check($sformatf("frame_ready dut%0d data %0h", id, e[7:0]), rseen, one);
    end
  endtask

  initial fork
    monitor(0, 4, 1);
    monitor(1, 4, 0);
    monitor(2, 1, 1);
  join

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 'start' of a frame; returns in the done cycle.
  task automatic wait_done(input int id, input int start, input int exp, input string name);
    int n;
    n = start;
    while (done_v[id] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check(name, 64'(n), 64'(exp));
  endtask

  initial begin
    int dcnt;
    // reset state
    step(); step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_tx dut%0d", i), 64'(tx_v[i]), 64'd1);
      check($sformatf("rst_ready dut%0d", i), 64'(ready_v[i]), 64'd1);
      check($sformatf("rst_busy dut%0d", i), 64'(busy_v[i]), 64'd0);
      check($sformatf("rst_done dut%0d", i), 64'(done_v[i]), 64'd0);
    end
    // reset wins over load
    l0 = 1; d0 = 8'h99;
    step();
    check("rst_load_ready", 64'(ready_v[0]), 64'd1);
    check("rst_load_tx", 64'(tx_v[0]), 64'd1);
    l0 = 0; rst = 0;
    step(); step();

    // 1: 0xA5, parity 0, 44 cycles
    d0 = 8'hA5; l0 = 1; push(0, {1'b0, 8'hA5});
    step(); l0 = 0;
    check("a5_busy", 64'(busy_v[0]), 64'd1);
    wait_done(0, 1, 44, "a5_len");
    step(); step();

    // 2: 0x07 with parity (1) and without (40 cycles)
    d0 = 8'h07; l0 = 1; push(0, {1'b1, 8'h07});
    step(); l0 = 0;
    wait_done(0, 1, 44, "07_par_len");
    step();
    d1 = 8'h07; l1 = 1; push(1, {1'b0, 8'h07});
    step(); l1 = 0;
    wait_done(1, 1, 40, "07_nopar_len");
    step(); step();

    // 3: load held, 0x3C then 0xC3 back to back
    d0 = 8'h3C; l0 = 1; push(0, {1'b0, 8'h3C});
    step();
    d0 = 8'hC3; push(0, {1'b0, 8'hC3});
    wait_done(0, 1, 44, "b2b_first_len");
    step();
    check("b2b_no_gap", 64'(tx_v[0]), 64'd0);
    l0 = 0;
    wait_done(0, 1, 44, "b2b_second_len");
    step(); step();

    // 4: load and data changes while busy are ignored
    d0 = 8'h12; l0 = 1; push(0, {1'b0, 8'h12});
    step(); l0 = 0;
    d0 = 8'hFF; l0 = 1;
    step(); step(); step();
    l0 = 0;
    wait_done(0, 4, 44, "busy_ignore_len");
    repeat (20) step();
    check("busy_ignore_idle", 64'(ready_v[0]), 64'd1);

    // 5: reset in cycle 20 of a 0x5A frame
    d0 = 8'h5A; l0 = 1;
    step(); l0 = 0;
    repeat (19) step();
    rst = 1;
    step();
    rst = 0;
    check("midrst_tx", 64'(tx_v[0]), 64'd1);
    check("midrst_ready", 64'(ready_v[0]), 64'd1);
    check("midrst_busy", 64'(busy_v[0]), 64'd0);
    dcnt = 0;
    repeat (50) begin
      if (done_v[0] === 1'b1) dcnt++;
      step();
    end
    check("midrst_no_done", 64'(dcnt), 64'd0);
    l0 = 1; push(0, {1'b0, 8'h5A});
    step(); l0 = 0;
    wait_done(0, 1, 44, "midrst_refill_len");
    step(); step();

    // 6: CLKS_PER_BIT=1, 0x81
    d2 = 8'h81; l2 = 1; push(2, {1'b0, 8'h81});
    step(); l2 = 0;
    wait_done(2, 1, 11, "cpb1_len");
    repeat (5) step();

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
